line_tx_packetizer: RTL and testbench
=====================================

Name: line_tx_packetizer

Overview:
- Downstream consumer of the image line buffer in the receive chain.
- On each line-ready pulse it reads LINE_LEN 8-bit envelope samples from the buffer read port (1-cycle read latency).
- It frames them as header, line number, samples and checksum, and streams the bytes over a valid/ready byte interface to the CC3200 SPI serializer.
- It absorbs serializer back-pressure without losing or duplicating samples.

Parameters:
LINE_LEN, 512, samples per line (power of two, ≥4)
ADDR_W, 9, buffer address width, log2(LINE_LEN)
HDR0, 8'hA5, first header byte
HDR1, 8'h5A, second header byte

Ports:
clk_50M  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
line_start  in  1  single-cycle pulse: a new line is complete in the buffer
line_num  in  8  line index, sampled when line_start is accepted
buf_rd_en  out  1  buffer read strobe
buf_addr  out  ADDR_W  buffer read address
buf_data  in  8  read data, valid exactly 1 cycle after buf_rd_en
tx_data  out  8  output byte
tx_valid  out  1  tx_data is valid
tx_ready  in  1  serializer accepts the byte; a transfer occurs when tx_valid & tx_ready
tx_last  out  1  high with the checksum byte
busy  out  1  a packet is in progress
overrun_cnt  out  8  number of line_start pulses dropped while busy; saturates at 255

Behaviour:
- Reset (synchronous, high): on the next edge the following are all 0:
  - state=IDLE
  - tx_valid, tx_last, busy, buf_rd_en, buf_addr, overrun_cnt
  - FIFO and checksum cleared
- Reset mid-packet aborts the packet; no partial bytes are emitted afterwards.
- FSM states are IDLE, HDR0, HDR1, LNUM, DATA, CKSUM.
  - IDLE -> HDR0 on line_start; latch line_num; busy=1 from the next cycle.
  - HDR0 -> HDR1 -> LNUM -> DATA: each advance happens on a transfer.
  - DATA -> CKSUM after transfer of sample LINE_LEN-1.
  - CKSUM -> IDLE on transfer.
- Latency: line_start at cycle T gives tx_valid=1, tx_data=HDR0 at T+1.
- Packet length is LINE_LEN+4 bytes. Order: HDR0, HDR1, line_num, samples at addr 0..LINE_LEN-1, checksum.
- Checksum = (line_num + sum of all samples) mod 256. Header bytes are excluded.
- Output stability: while tx_valid & !tx_ready, tx_data and tx_last hold stable. tx_valid never drops without a transfer, except on reset.
- Prefetch:
  - 2-entry sample FIFO plus an in-flight counter.
  - Issue buf_rd_en only when (FIFO occupancy + in-flight) < 2 and reads remain.
  - Prefetch may start in HDR0, so DATA streams at 1 byte/cycle when tx_ready is held high.
  - buf_addr increments after each read, stops at LINE_LEN-1, and never wraps within a packet.
- Addressing: buf_addr returns to 0 at packet start. No more than LINE_LEN reads are issued per packet.
- FIFO never overflows. A DATA byte is presented only when the FIFO is non-empty; tx_valid=0 otherwise.
- line_start while busy:
  - The pulse is ignored and overrun_cnt increments, saturating at 255.
  - Exception: if it coincides with the CKSUM transfer cycle, it is accepted as a new packet. The next cycle is HDR0 with no gap, and overrun_cnt is unchanged.
- line_num changes while busy have no effect on the current packet.
- busy stays high through the CKSUM transfer cycle and is low the cycle after, unless a new packet was accepted.

Test Plan:
- Ramp with no back-pressure: buf_data=addr[7:0], line_num=8'h07, tx_ready=1, line_start at T.
  - Required: 516 contiguous bytes A5,5A,07,00..FF,00..FF,07 at T+1..T+516.
  - tx_last only at T+516; busy=0 at T+517; exactly 512 reads.
- Random back-pressure: same data, tx_ready random at 30% duty.
  - Required: identical byte sequence, no duplicates or drops.
  - tx_data stable during every stall; reads never exceed 2 ahead of consumption.
- Overrun: 3 line_start pulses during DATA.
  - Required: overrun_cnt=3, and the current packet is unaffected.
  - Also run 300 dropped pulses; required: overrun_cnt saturates at 255.
- Back-to-back packets: line_start in the CKSUM transfer cycle.
  - Required: next cycle shows tx_data=A5 with tx_valid=1, busy stays 1, overrun_cnt unchanged, buf_addr restarts at 0.
- Reset mid-DATA: assert reset at sample 100 for 1 cycle.
  - Required: next cycle tx_valid=0, busy=0, buf_addr=0, overrun_cnt=0.
  - A following line_start yields a complete correct packet.
- All-FF data with line_num=8'hFF, ready=1.
  - Required: checksum = (255 + 512*255) mod 256 = 8'hFF.

Source files
------------

// File: rtl/line_tx_packetizer.sv
// line_tx_packetizer: frames one image line from the line buffer into a byte
// packet (HDR0, HDR1, line number, LINE_LEN samples, checksum) and streams it
// over a valid/ready byte interface to the SPI serializer. Buffer reads are
// prefetched into a 2-entry FIFO so the DATA phase sustains one byte per cycle
// while the serializer can stall the stream at any time.
module line_tx_packetizer #(
  parameter int         LINE_LEN = 512,
  parameter int         ADDR_W   = 9,
  parameter logic [7:0] HDR0     = 8'hA5,
  parameter logic [7:0] HDR1     = 8'h5A
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              line_start,
  input  logic [7:0]        line_num,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_LNUM  = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_CKSUM = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [7:0]        lnum_q;
  logic [7:0]        cksum_q;
  logic [ADDR_W-1:0] smp_cnt_q;   // samples already sent in this packet
  logic              rd_done_q;   // last address of the line has been read

  logic [7:0]        fifo_mem [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fifo_cnt_q;
  logic              inflight_q;  // a read was issued last cycle; data lands now

  logic              xfer;
  logic              pop;
  logic              push;
  logic              start_ok;
  logic              prefetch_win;
  logic [2:0]        room_used;
  logic              rd_fire;

  assign xfer     = tx_valid & tx_ready;
  assign pop      = (state_q == ST_DATA) & xfer;
  assign push     = inflight_q;
  // A new line is taken when idle, or exactly on the checksum handoff so that
  // consecutive packets run with no idle cycle in between.
  assign start_ok = line_start & ((state_q == ST_IDLE) | ((state_q == ST_CKSUM) & xfer));

  // Occupancy is counted after this cycle's pop, otherwise a read could only
  // be issued every other cycle and DATA would bubble at full rate.
  assign prefetch_win = (state_q == ST_HDR0) | (state_q == ST_HDR1) |
                        (state_q == ST_LNUM) | (state_q == ST_DATA);
  assign room_used    = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign rd_fire      = ~reset & prefetch_win & ~rd_done_q & (room_used < 3'd2);
  assign buf_rd_en    = rd_fire;

  assign busy    = (state_q != ST_IDLE);
  assign tx_last = (state_q == ST_CKSUM);

  // Output byte and valid are decoded from state and FIFO head, both of which
  // only change on a transfer, so they hold steady through a stall.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_HDR0:  begin tx_valid = 1'b1;               tx_data = HDR0;               end
      ST_HDR1:  begin tx_valid = 1'b1;               tx_data = HDR1;               end
      ST_LNUM:  begin tx_valid = 1'b1;               tx_data = lnum_q;             end
      ST_DATA:  begin tx_valid = (fifo_cnt_q != 0);  tx_data = fifo_mem[rd_ptr_q]; end
      ST_CKSUM: begin tx_valid = 1'b1;               tx_data = cksum_q;            end
      default:  begin tx_valid = 1'b0;               tx_data = 8'h00;              end
    endcase
  end

  // Next-state decode: header/line-number states advance on transfer, DATA
  // leaves after the final sample, CKSUM returns to IDLE or restarts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_HDR0;
      ST_HDR0:  if (xfer)     state_d = ST_HDR1;
      ST_HDR1:  if (xfer)     state_d = ST_LNUM;
      ST_LNUM:  if (xfer)     state_d = ST_DATA;
      ST_DATA:  if (pop && (smp_cnt_q == LAST_ADDR)) state_d = ST_CKSUM;
      ST_CKSUM: if (xfer)     state_d = start_ok ? ST_HDR0 : ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Packet control: state, latched line number, running checksum, sample
  // count and read address.
  always_ff @(posedge clk_50M) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      lnum_q    <= 8'h00;
      cksum_q   <= 8'h00;
      smp_cnt_q <= '0;
      buf_addr  <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        lnum_q    <= line_num;
        cksum_q   <= line_num;
        smp_cnt_q <= '0;
        buf_addr  <= '0;
        rd_done_q <= 1'b0;
      end else begin
        if (pop) begin
          cksum_q   <= cksum_q + fifo_mem[rd_ptr_q];
          smp_cnt_q <= smp_cnt_q + 1'b1;
        end
        if (rd_fire) begin
          if (buf_addr == LAST_ADDR) rd_done_q <= 1'b1;
          else                       buf_addr  <= buf_addr + 1'b1;
        end
      end
    end
  end

  // Sample FIFO storage: written by the read data one cycle after each read.
  always_ff @(posedge clk_50M) begin
    // NOTE: the storage array has no reset; the cleared occupancy count gates
    // every read of it, so stale contents can never reach the output.
    if (push) fifo_mem[wr_ptr_q] <= buf_data;
  end

  // Sample FIFO pointers, occupancy and the read-in-flight flag.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_fire;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Saturating count of line_start pulses that arrive while a packet is busy.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      overrun_cnt <= 8'h00;
    end else if (line_start && !start_ok && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_line_tx_packetizer.sv
// Testbench for line_tx_packetizer: directed packets with a scoreboard queue
// of expected bytes, drained by an independent output monitor.
`timescale 1ns/1ps
module tb_line_tx_packetizer;

  localparam int LINE_LEN = 512;
  localparam int ADDR_W   = 9;

  logic              clk_50M    = 1'b0;
  logic              reset      = 1'b1;
  logic              line_start = 1'b0;
  logic [7:0]        line_num   = 8'h00;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data   = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready   = 1'b1;
  logic              tx_last;
  logic              busy;
  logic [7:0]        overrun_cnt;

  line_tx_packetizer #(
    .LINE_LEN(LINE_LEN), .ADDR_W(ADDR_W), .HDR0(8'hA5), .HDR1(8'h5A)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .line_start (line_start),
    .line_num   (line_num),
    .buf_rd_en  (buf_rd_en),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy),
    .overrun_cnt(overrun_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  // Line buffer model with one cycle of read latency.
  logic [7:0] buf_mem [LINE_LEN];
  always @(posedge clk_50M) if (buf_rd_en) buf_data <= buf_mem[buf_addr];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic fill_mem(input bit all_ff);
    for (int i = 0; i < LINE_LEN; i++) buf_mem[i] = all_ff ? 8'hFF : 8'(i);
  endtask

  task automatic push_packet(input logic [7:0] lnum, input logic [7:0] cks);
    exp_q.push_back('{data: 8'hA5, last: 1'b0});
    exp_q.push_back('{data: 8'h5A, last: 1'b0});
    exp_q.push_back('{data: lnum,  last: 1'b0});
    for (int i = 0; i < LINE_LEN; i++) exp_q.push_back('{data: buf_mem[i], last: 1'b0});
    exp_q.push_back('{data: cks, last: 1'b1});
  endtask

  // Pulse line_start for one cycle and queue the expected packet.
  task automatic start_pkt(input logic [7:0] lnum, input logic [7:0] cks);
    cyc();
    line_num   = lnum;
    line_start = 1'b1;
    push_packet(lnum, cks);
    cyc();
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clk_50M);
      #2;
      n++;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  // Serializer ready: held high, or random with 30% duty.
  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk_50M);
      #1;
      tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  // Output monitor: pops the scoreboard on every transfer, checks stall
  // stability and per-packet read accounting.
  int         mon_pos       = 0;
  int         mon_rds       = 0;
  int         mon_used      = 0;
  int         mon_max_ahead = 0;
  logic       mon_stalled   = 1'b0;
  logic [7:0] mon_st_data   = 8'h00;
  logic       mon_st_last   = 1'b0;
  exp_t       mon_e;

  initial begin
    forever begin
      @(negedge clk_50M);
      if (reset) begin
        mon_pos = 0; mon_rds = 0; mon_used = 0; mon_max_ahead = 0; mon_stalled = 1'b0;
      end else begin
        if (mon_stalled) begin
          check("stall_valid_held", {31'd0, tx_valid}, 32'd1);
          check("stall_data_held", {24'd0, tx_data}, {24'd0, mon_st_data});
          check("stall_last_held", {31'd0, tx_last}, {31'd0, mon_st_last});
        end
        mon_stalled = tx_valid && !tx_ready;
        mon_st_data = tx_data;
        mon_st_last = tx_last;
        if (buf_rd_en) mon_rds++;
        if (tx_valid && tx_ready) begin
          if (mon_pos >= 3 && mon_pos < LINE_LEN + 3) mon_used++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {31'd0, tx_valid}, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("tx_data", {24'd0, tx_data}, {24'd0, mon_e.data});
            check("tx_last", {31'd0, tx_last}, {31'd0, mon_e.last});
          end
          mon_pos++;
        end
        if (mon_rds - mon_used > mon_max_ahead) mon_max_ahead = mon_rds - mon_used;
        if (tx_valid && tx_ready && tx_last) begin
          check("pkt_len", mon_pos, LINE_LEN + 4);
          check("pkt_reads", mon_rds, LINE_LEN);
          check("read_ahead_le2", {31'd0, (mon_max_ahead <= 2)}, 32'd1);
          mon_pos = 0; mon_rds = 0; mon_used = 0; mon_max_ahead = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int gaps, last_cnt, last_pos, n;

    fill_mem(1'b0);
    repeat (3) @(posedge clk_50M);
    #1 reset = 1'b0;
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_last", {31'd0, tx_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_en", {31'd0, buf_rd_en}, 32'd0);
    check("rst_addr", {23'd0, buf_addr}, 32'd0);
    check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);

    // Ramp, no back-pressure: bytes at T+1..T+516, idle at T+517.
    start_pkt(8'h07, 8'h07);
    #1;
    gaps = 0; last_cnt = 0; last_pos = 0;
    for (int i = 1; i <= LINE_LEN + 4; i++) begin
      if (i > 1) begin @(posedge clk_50M); #2; end
      if (i == 1) begin
        check("lat_valid", {31'd0, tx_valid}, 32'd1);
        check("lat_hdr0", {24'd0, tx_data}, 32'hA5);
        check("lat_busy", {31'd0, busy}, 32'd1);
      end
      if (!tx_valid) gaps++;
      if (tx_last) begin last_cnt++; last_pos = i; end
    end
    check("ramp_gaps", gaps, 0);
    check("ramp_last_count", last_cnt, 1);
    check("ramp_last_pos", last_pos, LINE_LEN + 4);
    @(posedge clk_50M); #2;
    check("ramp_busy_after", {31'd0, busy}, 32'd0);
    wait_idle("ramp", 10);

    // Random back-pressure, same packet.
    rdy_mode = 1;
    start_pkt(8'h07, 8'h07);
    wait_idle("random", 8000);
    rdy_mode = 0;

    // Three dropped pulses during DATA; line_num change must not leak.
    start_pkt(8'h10, 8'h10);
    repeat (20) cyc();
    for (int k = 0; k < 3; k++) begin
      line_start = 1'b1;
      line_num   = 8'hEE;
      cyc();
      line_start = 1'b0;
      cyc();
    end
    #1;
    check("overrun_3", {24'd0, overrun_cnt}, 32'd3);
    wait_idle("overrun", 1000);

    // Back-to-back: new line accepted in the checksum transfer cycle.
    start_pkt(8'h30, 8'h30);
    #1;
    n = 0;
    while (!tx_last && n < 1000) begin @(posedge clk_50M); #2; n++; end
    check("b2b_at_cksum", {31'd0, tx_last}, 32'd1);
    line_start = 1'b1;
    line_num   = 8'h31;
    push_packet(8'h31, 8'h31);
    @(posedge clk_50M);
    #1 line_start = 1'b0;
    #1;
    check("b2b_valid", {31'd0, tx_valid}, 32'd1);
    check("b2b_hdr0", {24'd0, tx_data}, 32'hA5);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_overrun", {24'd0, overrun_cnt}, 32'd3);
    check("b2b_addr", {23'd0, buf_addr}, 32'd0);
    wait_idle("b2b", 1000);

    // All-FF samples with line number FF: checksum FF.
    fill_mem(1'b1);
    start_pkt(8'hFF, 8'hFF);
    wait_idle("all_ff", 1000);
    fill_mem(1'b0);

    // 300 dropped pulses: counter saturates.
    start_pkt(8'h11, 8'h11);
    repeat (5) cyc();
    line_start = 1'b1;
    line_num   = 8'h99;
    repeat (300) cyc();
    line_start = 1'b0;
    cyc();
    #1;
    check("overrun_sat", {24'd0, overrun_cnt}, 32'd255);
    wait_idle("sat", 1000);

    // Reset while sample 100 is presented.
    start_pkt(8'h20, 8'h20);
    #1;
    n = 0;
    while (!(tx_valid && tx_data == 8'h64) && n < 1000) begin @(posedge clk_50M); #2; n++; end
    check("rst_mid_found", {24'd0, tx_data}, 32'h64);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk_50M);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addr", {23'd0, buf_addr}, 32'd0);
    check("rst_mid_overrun", {24'd0, overrun_cnt}, 32'd0);
    repeat (10) cyc();
    start_pkt(8'h22, 8'h22);
    wait_idle("after_rst", 1000);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
